// File: rtl/mem_arbiter.sv
// Per-access arbiter that shares one single-port RAM between a CPU port and a DMA port.
// Sequences the RAM address, write and read-latency timing, then pulses one ack per access.
module mem_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_be,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_be,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    input  logic [15:0] RAMout,
    output logic [15:0] RAMaddr,
    output logic [15:0] RAMin,
    output logic        we,
    output logic        be,
    output logic        owner,
    output logic        busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);
    localparam logic [2:0]    RD_LAT_C = 3'(RD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic [2:0]    cnt_q;
    logic          lat_we_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   c_rdata_q;
    logic [15:0]   d_rdata_q;
    logic          be_q;
    logic          we_q;
    logic          owner_q;
    logic          busy_q;
    logic          c_ack_q;
    logic          d_ack_q;
    logic          dma_win_d;

    // DMA takes the RAM when the CPU is idle or has starved it for STARVE_MAX grants.
    always_comb begin
        dma_win_d = 1'b0;
        if (d_req && (!c_req || (starve_q == STARVE_C))) begin
            dma_win_d = 1'b1;
        end else begin
            dma_win_d = 1'b0;
        end
    end

    // Access sequencer; every RAM-side and requester-side output is a register here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            starve_q  <= '0;
            cnt_q     <= 3'd0;
            lat_we_q  <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            c_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
            be_q      <= 1'b0;
            we_q      <= 1'b0;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        owner_q  <= dma_win_d;
                        lat_we_q <= dma_win_d ? d_we : c_we;
                        we_q     <= dma_win_d ? d_we : c_we;
                        be_q     <= dma_win_d ? d_be : c_be;
                        addr_q   <= dma_win_d ? d_addr : c_addr;
                        wdata_q  <= dma_win_d ? d_wdata : c_wdata;
                        busy_q   <= 1'b1;
                        state_q  <= S_ACCESS;
                        if (dma_win_d || !d_req) begin
                            starve_q <= '0;
                        end else if (starve_q != STARVE_C) begin
                            starve_q <= starve_q + 1'b1;
                        end else begin
                            starve_q <= starve_q;
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                S_ACCESS: begin
                    if (lat_we_q) begin
                        c_ack_q <= ~owner_q;
                        d_ack_q <= owner_q;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q   <= 3'd1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // RAMout is valid in the cycle where the count reaches RD_LAT.
                    if (cnt_q == RD_LAT_C) begin
                        if (owner_q) begin
                            d_rdata_q <= RAMout;
                        end else begin
                            c_rdata_q <= RAMout;
                        end
                        c_ack_q <= ~owner_q;
                        d_ack_q <= owner_q;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign RAMaddr = addr_q;
    assign RAMin   = wdata_q;
    assign we      = we_q;
    assign be      = be_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;
    assign c_ack   = c_ack_q;
    assign d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1 runs every scenario,
// a second with RD_LAT=3 checks the longer read latency.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        c_req, c_we, c_be, d_req, d_we, d_be;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [15:0] c_rdata, d_rdata, RAMout, RAMaddr, RAMin;
    logic        c_ack, d_ack, we, be, owner, busy;

    logic        c_req3, d_req3;
    logic [15:0] c_rdata3, d_rdata3, RAMout3, RAMaddr3, RAMin3;
    logic        c_ack3, d_ack3, we3, be3, owner3, busy3;

    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [7:0]  pipe1;
    logic [7:0]  pipe3 [0:2];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .RAMout(RAMout), .RAMaddr(RAMaddr), .RAMin(RAMin), .we(we), .be(be),
        .owner(owner), .busy(busy)
    );

    mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .c_req(c_req3), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata3), .c_ack(c_ack3),
        .d_req(d_req3), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_ack(d_ack3),
        .RAMout(RAMout3), .RAMaddr(RAMaddr3), .RAMin(RAMin3), .we(we3), .be(be3),
        .owner(owner3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: data appears RD_LAT cycles after the address is presented.
    always @(posedge clk) begin
        if (reset) begin
            mem1[8'h10] <= 16'h1234;
            mem1[8'h20] <= 16'hA5A5;
            mem3[8'h10] <= 16'h1234;
            pipe1       <= 8'h00;
            pipe3[0]    <= 8'h00;
            pipe3[1]    <= 8'h00;
            pipe3[2]    <= 8'h00;
        end else begin
            if (we)  mem1[RAMaddr[7:0]]  <= RAMin;
            if (we3) mem3[RAMaddr3[7:0]] <= RAMin3;
            pipe1    <= RAMaddr[7:0];
            pipe3[0] <= RAMaddr3[7:0];
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign RAMout  = mem1[pipe1];
    assign RAMout3 = mem3[pipe3[2]];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] order;
    int         n_acks;

    initial begin
        reset = 1'b1; c_req = 1'b1; d_req = 1'b1; c_req3 = 1'b0; d_req3 = 1'b0;
        c_we = 1'b0; c_be = 1'b0; d_we = 1'b0; d_be = 1'b0;
        c_addr = 16'h0000; c_wdata = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;

        // 1: reset with both requests high
        tick(); tick();
        check_eq("rst_acks",  {30'd0, c_ack, d_ack}, 32'd0);
        check_eq("rst_ctl",   {28'd0, we, be, busy, owner}, 32'd0);
        check_eq("rst_addr",  {RAMaddr, RAMin}, 32'd0);
        check_eq("rst_rdata", {c_rdata, d_rdata}, 32'd0);
        c_req = 1'b0; d_req = 1'b0; reset = 1'b0;
        tick();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // 2: CPU write 0x0040 <= 0xBEEF
        c_req = 1'b1; c_we = 1'b1; c_be = 1'b1; c_addr = 16'h0040; c_wdata = 16'hBEEF;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            tick();
            check_eq($sformatf("wr_we_c%0d", cyc), {31'd0, we}, {31'd0, cyc == 1});
            check_eq($sformatf("wr_cack_c%0d", cyc), {31'd0, c_ack}, {31'd0, cyc == 2});
            check_eq($sformatf("wr_dack_c%0d", cyc), {31'd0, d_ack}, 32'd0);
            check_eq($sformatf("wr_busy_c%0d", cyc), {31'd0, busy}, {31'd0, cyc != 3});
            check_eq($sformatf("wr_addr_c%0d", cyc), {16'd0, RAMaddr}, 32'h0040);
            if (cyc == 1) begin
                check_eq("wr_ramin", {16'd0, RAMin}, 32'hBEEF);
                check_eq("wr_be", {31'd0, be}, 32'd1);
            end
            if (cyc == 2) c_req = 1'b0;
        end
        check_eq("wr_mem", {16'd0, mem1[8'h40]}, 32'hBEEF);

        // 3: CPU read 0x0010 with RD_LAT=1 and RD_LAT=3
        c_req = 1'b1; c_req3 = 1'b1; c_we = 1'b0; c_be = 1'b0; c_addr = 16'h0010;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            check_eq($sformatf("rd_cack1_c%0d", cyc), {31'd0, c_ack}, {31'd0, cyc == 3});
            check_eq($sformatf("rd_cack3_c%0d", cyc), {31'd0, c_ack3}, {31'd0, cyc == 5});
            check_eq($sformatf("rd_we_c%0d", cyc), {30'd0, we, we3}, 32'd0);
            if (cyc == 3) begin
                check_eq("rd_data1", {16'd0, c_rdata}, 32'h1234);
                c_req = 1'b0;
            end
            if (cyc == 5) begin
                check_eq("rd_data3", {16'd0, c_rdata3}, 32'h1234);
                c_req3 = 1'b0;
            end
        end

        // 4: simultaneous CPU read 0x0010 and DMA read 0x0020
        c_req = 1'b1; c_addr = 16'h0010; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            check_eq($sformatf("arb_cack_c%0d", cyc), {31'd0, c_ack}, {31'd0, cyc == 3});
            check_eq($sformatf("arb_dack_c%0d", cyc), {31'd0, d_ack}, {31'd0, cyc == 7});
            check_eq($sformatf("arb_owner_c%0d", cyc), {31'd0, owner}, {31'd0, cyc >= 5});
            check_eq($sformatf("arb_drdata_c%0d", cyc), {16'd0, d_rdata},
                     (cyc >= 7) ? 32'hA5A5 : 32'h0000);
            if (cyc == 3) begin
                check_eq("arb_crdata", {16'd0, c_rdata}, 32'h1234);
                c_req = 1'b0;
            end
            if (cyc == 5) check_eq("arb_daddr", {16'd0, RAMaddr}, 32'h0020);
            if (cyc == 7) d_req = 1'b0;
        end

        // 5: both requesters always asking, expect C,C,C,C,D,C,C,C,C,D
        c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0050; c_wdata = 16'h1111;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h2222;
        order = 10'd0; n_acks = 0;
        for (int cyc = 0; cyc < 100 && n_acks < 10; cyc++) begin
            tick();
            if (c_ack || d_ack) begin
                order[n_acks] = d_ack;
                check_eq($sformatf("starve_owner_%0d", n_acks), {31'd0, owner}, {31'd0, d_ack});
                n_acks++;
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        check_eq("starve_count", n_acks, 32'd10);
        check_eq("starve_order", {22'd0, order}, 32'h0000_0210);
        tick(); tick();
        check_eq("starve_idle", {31'd0, busy}, 32'd0);

        // 6: reset during WAIT of a DMA read
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        tick();
        check_eq("rw_access", {31'd0, busy}, 32'd1);
        tick();
        check_eq("rw_wait_noack", {31'd0, d_ack}, 32'd0);
        reset = 1'b1; d_req = 1'b0;
        tick();
        check_eq("rw_dack",  {31'd0, d_ack}, 32'd0);
        check_eq("rw_busy",  {31'd0, busy}, 32'd0);
        check_eq("rw_drdata", {16'd0, d_rdata}, 32'd0);
        check_eq("rw_ctl", {29'd0, we, owner, be}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("rw_after", {30'd0, d_ack, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
